// File: rtl/stack_pkg.sv
// Shared types and helpers for the operand stack: operation decode and
// modulo-DEPTH pointer arithmetic.
package stack_pkg;

  // Encoding is {push, pop}
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

  function automatic int ptr_dec(input int p, input int depth);
    return (p == 0) ? depth - 1 : p - 1;
  endfunction

endpackage

// File: rtl/operand_stack.sv
// LIFO operand store for the stack CPU: circular buffer with a top pointer,
// top two entries exposed combinationally for the ALU.
module operand_stack
  import stack_pkg::*;
#(
  parameter int WORD  = 4,
  parameter int DEPTH = 2,
  parameter int WRAP  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [WORD-1:0] din,
  output logic [WORD-1:0] top,
  output logic [WORD-1:0] next,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow,
  output logic            err
);

  localparam int PW = $clog2(DEPTH);

  logic [WORD-1:0] mem [DEPTH];
  logic [PW-1:0]   tp, tp_n, tp_inc, tp_dec, wa;
  logic [CW-1:0]   count_n;
  logic            we, ov_n, un_n;
  stack_op_e       op;

  assign op     = stack_op_e'({push, pop});
  assign tp_inc = PW'(ptr_inc(32'(tp), DEPTH));
  assign tp_dec = PW'(ptr_dec(32'(tp), DEPTH));

  always_comb begin
    tp_n    = tp;
    count_n = count;
    we      = 1'b0;
    wa      = tp_inc;
    ov_n    = 1'b0;
    un_n    = 1'b0;
    unique case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (!full) begin
          tp_n    = tp_inc;
          count_n = count + 1'b1;
          we      = 1'b1;
        end else begin
          ov_n = 1'b1;
          // Wrap mode: the slot past the top is the oldest entry, overwrite it
          if (WRAP != 0) begin
            tp_n = tp_inc;
            we   = 1'b1;
          end
        end
      end
      OP_POP: begin
        if (!empty) begin
          tp_n    = tp_dec;
          count_n = count - 1'b1;
        end else begin
          un_n = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (!empty) begin
          wa = tp;
          we = 1'b1;
        end else begin
          tp_n    = tp_inc;
          count_n = CW'(1);
          we      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      err       <= 1'b0;
    end else begin
      tp        <= tp_n;
      count     <= count_n;
      overflow  <= ov_n;
      underflow <= un_n;
      err       <= err | ov_n | un_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = empty ? '0 : mem[tp];
  assign next  = (count > CW'(1)) ? mem[tp_dec] : '0;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: two instances (reject and wrap on full) share one
// directed stimulus and are compared every cycle against a bottom-first array model.
module tb_operand_stack;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [3:0] din;

  logic [3:0] top0, next0, top1, next1;
  logic [2:0] count0, count1;
  logic       empty0, full0, ov0, un0, err0;
  logic       empty1, full1, ov1, un1, err1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_stack #(.WORD(4), .DEPTH(4), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .top(top0), .next(next0), .count(count0), .empty(empty0), .full(full0),
    .overflow(ov0), .underflow(un0), .err(err0));

  operand_stack #(.WORD(4), .DEPTH(4), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .top(top1), .next(next1), .count(count1), .empty(empty1), .full(full1),
    .overflow(ov1), .underflow(un1), .err(err1));

  // Model: m[i][0] is the bottom, m[i][sz-1] the top
  logic [3:0] m [2][4];
  int         sz [2];
  bit         m_ov [2], m_un [2], m_err [2];
  bit         armed = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sz[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_err[i] = 0;
      end else begin
        m_ov[i] = 0; m_un[i] = 0;
        if (push && !pop) begin
          if (sz[i] < 4) begin
            m[i][sz[i]] = din; sz[i]++;
          end else begin
            m_ov[i] = 1;
            if (i == 1) begin
              for (int k = 0; k < 3; k++) m[i][k] = m[i][k+1];
              m[i][3] = din;
            end
          end
        end else if (!push && pop) begin
          if (sz[i] > 0) sz[i]--; else m_un[i] = 1;
        end else if (push && pop) begin
          if (sz[i] > 0) m[i][sz[i]-1] = din;
          else begin m[i][0] = din; sz[i] = 1; end
        end
        m_err[i] = m_err[i] | m_ov[i] | m_un[i];
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_top(input int i);
    return (sz[i] >= 1) ? int'(m[i][sz[i]-1]) : 0;
  endfunction

  function automatic int exp_next(input int i);
    return (sz[i] >= 2) ? int'(m[i][sz[i]-2]) : 0;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      check("d0.top", top0, exp_top(0));
      check("d0.next", next0, exp_next(0));
      check("d0.count", count0, sz[0]);
      check("d0.empty", empty0, sz[0] == 0);
      check("d0.full", full0, sz[0] == 4);
      check("d0.overflow", ov0, m_ov[0]);
      check("d0.underflow", un0, m_un[0]);
      check("d0.err", err0, m_err[0]);
      check("d1.top", top1, exp_top(1));
      check("d1.next", next1, exp_next(1));
      check("d1.count", count1, sz[1]);
      check("d1.empty", empty1, sz[1] == 0);
      check("d1.full", full1, sz[1] == 4);
      check("d1.overflow", ov1, m_ov[1]);
      check("d1.underflow", un1, m_un[1]);
      check("d1.err", err1, m_err[1]);
    end
  end

  task automatic step(input bit r, input bit pu, input bit po, input logic [3:0] d);
    rst = r; push = pu; pop = po; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    step(1, 0, 0, 0);
    check("lit.reset_count", count0, 0);
    check("lit.reset_empty", empty0, 1);

    step(0, 1, 0, 1); step(0, 1, 0, 2); step(0, 1, 0, 3);
    check("lit.p3_count", count0, 3);
    check("lit.p3_top", top0, 3);
    check("lit.p3_next", next0, 2);
    check("lit.p3_full", full0, 0);
    step(0, 0, 1, 0);
    check("lit.pop_top", top0, 2);
    check("lit.pop_next", next0, 1);
    check("lit.pop_count", count0, 2);

    step(1, 0, 0, 0);
    for (int v = 1; v <= 4; v++) step(0, 1, 0, 4'(v));
    step(0, 1, 0, 5);
    check("lit.ovf_full", full0, 1);
    check("lit.ovf_top", top0, 4);
    check("lit.ovf_pulse", ov0, 1);
    check("lit.wrap_top", top1, 5);
    check("lit.wrap_next", next1, 4);
    step(0, 1, 0, 6);
    check("lit.wrap_top6", top1, 6);
    check("lit.wrap_count", count1, 4);
    step(0, 0, 0, 0);
    check("lit.ovf_drop", ov0, 0);
    check("lit.err_sticky", err0, 1);
    for (int k = 0; k < 4; k++) begin
      check("lit.wrap_popseq", top1, 6 - k);
      check("lit.rej_popseq", top0, 4 - k);
      step(0, 0, 1, 0);
    end
    check("lit.drain_empty", empty0, 1);
    check("lit.drain_top", top0, 0);
    check("lit.drain_next", next0, 0);

    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("lit.unf_pulse", un0, 1);
    check("lit.unf_err", err0, 1);
    step(0, 1, 1, 9);
    check("lit.repl_empty_count", count0, 1);
    check("lit.repl_empty_top", top0, 9);
    check("lit.repl_empty_unf", un0, 0);

    step(1, 0, 0, 0);
    step(0, 1, 0, 7); step(0, 1, 0, 8);
    step(0, 1, 1, 4'hA);
    check("lit.repl_top", top0, 10);
    check("lit.repl_next", next0, 7);
    check("lit.repl_count", count0, 2);

    step(0, 1, 0, 1);
    step(1, 1, 0, 4'hF);
    check("lit.rstpush_count", count0, 0);
    check("lit.rstpush_empty", empty0, 1);
    check("lit.rstpush_err", err0, 0);
    check("lit.rstpush_top", top0, 0);
    step(0, 1, 0, 3);
    check("lit.after_rst_count", count0, 1);
    check("lit.after_rst_top", top0, 3);

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Parametrised synchronous LIFO operand store for the stack CPU; it replaces the edge-on-push/pop stack.
- Single clock; push, pop and replace are sampled as level enables.
- Exposes the top two entries combinationally to feed the ALU A/B inputs.
- Tracks occupancy, full/empty, and overflow/underflow errors; full-stack pushes are either rejected or drop the bottom entry, by parameter.

Parameters:
WORD, 4, data width in bits (>=1)
DEPTH, 2, number of entries (>=2, need not be a power of two)
WRAP, 0, 0 = reject push when full; 1 = push when full discards the oldest (bottom) entry
CW, $clog2(DEPTH+1), width of count (derived; not to be overridden)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous reset, active-high
push  in  1  push din this cycle
pop  in  1  pop top this cycle
din  in  WORD  data to push
top  out  WORD  entry at top of stack (ALU B operand)
next  out  WORD  entry below top (ALU A operand)
count  out  CW  number of valid entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  one-cycle pulse: rejected push (WRAP=0) or discarded bottom (WRAP=1)
underflow  out  1  one-cycle pulse: pop with count == 0
err  out  1  sticky OR of overflow/underflow; cleared only by rst

Behaviour:
- Reset (rst=1 at clk edge): count=0, top pointer=0, overflow=underflow=err=0. Storage contents are don't-care.
- rst has priority over push/pop in the same cycle.
- Storage is a circular buffer of DEPTH words with a top pointer tp. Increment/decrement wrap explicitly at DEPTH (DEPTH-1 -> 0, 0 -> DEPTH-1).
- top = mem[tp] when count>=1, else 0.
- next = mem[tp-1 mod DEPTH] when count>=2, else 0.
- top and next are combinational from registered state, so an edge's operation is visible immediately after that edge (zero-cycle read, one-cycle write).
- Operation per edge, decoded from {push,pop}:
  - 00 NOP: no change; pulses low.
  - 10 PUSH, count<DEPTH: tp+=1; mem[tp]=din; count+=1.
  - 10 PUSH, count==DEPTH, WRAP=0: no state change; overflow=1.
  - 10 PUSH, count==DEPTH, WRAP=1: tp+=1; mem[tp]=din (overwrites bottom); count stays DEPTH; overflow=1.
  - 01 POP, count>=1: tp-=1; count-=1; the popped word is not cleared.
  - 01 POP, count==0: no state change; underflow=1.
  - 11 REPLACE, count>=1: mem[tp]=din; tp and count unchanged (pop-then-push, single cycle).
  - 11 REPLACE, count==0: behaves as PUSH (count becomes 1); no underflow.
- overflow/underflow are registered and high for exactly the cycle after the offending edge. err sets on the same edge and holds until rst.
- empty/full are derived combinationally from count; never both high.
- Reset mid-sequence discards all entries; the first push after reset lands at count=1.

Decomposition:
- Package stack_pkg: stack_op_e {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE}, the 2-bit encoding of {push,pop}, and the ptr_inc/ptr_dec functions for modulo-DEPTH pointer arithmetic.
- No sub-module; storage and pointer logic stay in operand_stack. The ALU consumes top/next externally.

Test Plan:
- WORD=4, DEPTH=4, WRAP=0: rst, push 1,2,3 -> count=3, top=3, next=2, empty=0, full=0; pop -> top=2, next=1, count=2.
- Same config: push 1,2,3,4 then push 5 -> full=1, top=4, count=4, overflow pulse 1 cycle, err=1 and stays high; pop x4 -> empty=1, top=0, next=0.
- WRAP=1: push 1..4 then push 5,6 -> top=6, next=5, count=4, overflow pulses twice; pop x4 -> returns 6,5,4,3, then empty.
- Empty stack: pop -> underflow pulse, count=0, err=1; push=pop=1 with din=9 -> count=1, top=9, no underflow.
- REPLACE: push 7,8, then push=pop=1 with din=A -> top=A, next=7, count=2.
- rst asserted together with push (din=F) at count=3 -> count=0, empty=1, err=0, top=0 after the edge.
